// File: rtl/des_subkey_sched_dec.sv
// Sequential DES key schedule: emits one PC-2 subkey per valid/ready handshake, K16 first, K1 last.
// Define KEYSCHED_ENC_EN to add a 'mode' input that selects the forward K1..K16 order instead.
module des_subkey_sched_dec #(
    parameter int KEY_W    = 56,
    parameter int SUBKEY_W = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
`ifdef KEYSCHED_ENC_EN
    input  logic                mode,
`endif
    input  logic [KEY_W-1:0]    key_in,
    output logic                busy,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [3:0]          round,
    output logic                done
);

    localparam int HALF_W = KEY_W / 2;

    // PC-2 selection, 1-based over C||D with bit 1 = MSB of C
    localparam int PC2 [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q;
    logic [KEY_W-1:0]  cd_q;
    logic [3:0]        round_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
`ifdef KEYSCHED_ENC_EN
    logic              mode_q;
`endif

    logic              one_step;
    logic [HALF_W-1:0] c_cur;
    logic [HALF_W-1:0] d_cur;
    logic [KEY_W-1:0]  step_d;
    logic [KEY_W-1:0]  load_d;

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] h, input logic two);
        return two ? {h[1:0], h[HALF_W-1:2]} : {h[0], h[HALF_W-1:1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] h, input logic two);
        return two ? {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]} : {h[HALF_W-2:0], h[HALF_W-1]};
    endfunction

    assign c_cur    = cd_q[KEY_W-1:HALF_W];
    assign d_cur    = cd_q[HALF_W-1:0];
    // Single-bit steps fall on the transitions between shift-by-1 rounds (1, 2, 9, 16)
    assign one_step = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);

    always_comb begin
        step_d = {rotr(c_cur, !one_step), rotr(d_cur, !one_step)};
        load_d = key_in;
`ifdef KEYSCHED_ENC_EN
        if (mode_q) begin
            step_d = {rotl(c_cur, !one_step), rotl(d_cur, !one_step)};
        end
        // Encrypt starts at C1D1, which is one left rotation past C0D0
        if (mode) begin
            load_d = {rotl(key_in[KEY_W-1:HALF_W], 1'b0), rotl(key_in[HALF_W-1:0], 1'b0)};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cd_q    <= '0;
            round_q <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef KEYSCHED_ENC_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cd_q    <= load_d;
                        round_q <= 4'd0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef KEYSCHED_ENC_EN
                        mode_q  <= mode;
`endif
                    end
                end
                RUN: begin
                    if (valid_q && subkey_ready) begin
                        if (round_q == 4'd15) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            round_q <= round_q + 4'd1;
                            cd_q    <= step_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < SUBKEY_W; gi++) begin : g_pc2
        assign subkey[SUBKEY_W-1-gi] = cd_q[KEY_W-PC2[gi]];
    end

    assign busy         = busy_q;
    assign subkey_valid = valid_q;
    assign round        = round_q;
    assign done         = done_q;

endmodule

// File: tb/tb_des_subkey_sched_dec.sv
// Randomized scoreboard bench for des_subkey_sched_dec against a forward FIPS key-schedule model.
`timescale 1ns/1ps
module tb_des_subkey_sched_dec;

    localparam logic [55:0] GOLD_KEY = 56'hF0CCAAF556678F;
    localparam logic [47:0] GOLD_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] GOLD_K2  = 48'h79AED9DBC9E5;
    localparam logic [47:0] GOLD_K16 = 48'hCB3D8B0E17F5;

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        subkey_ready = 1'b0;
    logic        mode = 1'b0;
    logic [55:0] key_in = '0;
    logic        busy;
    logic        subkey_valid;
    logic        done;
    logic [47:0] subkey;
    logic [3:0]  round;

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  rd;
    } exp_t;

    exp_t        sb[$];
    logic [47:0] acc_log[$];
    logic [47:0] ref_log[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rand_ready = 1'b0;
    bit          exp_done = 1'b0;
    bit          hold_v = 1'b0;
    logic [47:0] hold_sk;
    logic [3:0]  hold_rd;

    des_subkey_sched_dec dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
`ifdef KEYSCHED_ENC_EN
        .mode         (mode),
`endif
        .key_in       (key_in),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .round        (round),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        subkey_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [47:0] r;
        cd = {c, d};
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
        return r;
    endfunction

    // Forward FIPS schedule with left shifts, then queued in the order the DUT must emit
    task automatic push_sched(input logic [55:0] k, input bit enc);
        logic [47:0] ks [1:16];
        logic [27:0] c;
        logic [27:0] d;
        exp_t        e;
        c = k[55:28];
        d = k[27:0];
        for (int i = 1; i <= 16; i++) begin
            for (int s = 0; s < SHIFTS[i-1]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = pc2(c, d);
        end
        for (int r = 0; r < 16; r++) begin
            e.sk = enc ? ks[r+1] : ks[16-r];
            e.rd = r[3:0];
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input logic [55:0] k, input bit enc);
        start  = 1'b1;
        key_in = k;
        mode   = enc;
        push_sched(k, enc);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (i == 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done expected done within 400 cycles", tag);
        end
    endtask

    task automatic wait_round(input logic [3:0] r);
        int i;
        for (i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (subkey_valid && round == r) break;
        end
        if (i == 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_round: got no round %0d expected it within 400 cycles", r);
        end
    endtask

    task automatic cmp_logs(input string tag);
        chk({tag, "_len"}, 64'(acc_log.size()), 64'd16);
        if (acc_log.size() == 16 && ref_log.size() == 16) begin
            for (int i = 0; i < 16; i++) chk($sformatf("%s_k%0d", tag, i), 64'(acc_log[i]), 64'(ref_log[i]));
        end
    endtask

    function automatic logic [55:0] rand_key();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[55:0];
    endfunction

    // Monitor: pops an expectation on every accepted subkey, checks done and stall stability
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            exp_done = 1'b0;
            hold_v   = 1'b0;
        end else begin
            chk("done", 64'(done), 64'(exp_done));
            exp_done = 1'b0;
            if (hold_v && subkey_valid) begin
                chk("stall_subkey", 64'(subkey), 64'(hold_sk));
                chk("stall_round", 64'(round), 64'(hold_rd));
            end
            hold_v = 1'b0;
            if (subkey_valid) begin
                if (subkey_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_handshake: got subkey %h expected none", subkey);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("subkey_r%0d", e.rd), 64'(subkey), 64'(e.sk));
                        chk("round", 64'(round), 64'(e.rd));
                        acc_log.push_back(subkey);
                        if (e.rd == 4'd15) exp_done = 1'b1;
                    end
                end else begin
                    hold_v  = 1'b1;
                    hold_sk = subkey;
                    hold_rd = round;
                end
            end
        end
    end

    initial begin
        bit          enc;
        logic [55:0] k;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_round", 64'(round), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_subkey", 64'(subkey), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Golden key, ready held high
        acc_log.delete();
        do_start(GOLD_KEY, 1'b0);
        wait_done("gold");
        chk("gold_len", 64'(acc_log.size()), 64'd16);
        if (acc_log.size() == 16) begin
            chk("gold_K16", 64'(acc_log[0]), 64'(GOLD_K16));
            chk("gold_K2", 64'(acc_log[14]), 64'(GOLD_K2));
            chk("gold_K1", 64'(acc_log[15]), 64'(GOLD_K1));
        end
        ref_log = acc_log;
        @(posedge clk);
        #1;

        // Same key, ready toggling
        acc_log.delete();
        rand_ready = 1'b1;
        do_start(GOLD_KEY, 1'b0);
        wait_done("stall");
        cmp_logs("stall");
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // start mid-schedule must be ignored
        acc_log.delete();
        do_start(GOLD_KEY, 1'b0);
        wait_round(4'd5);
        start  = 1'b1;
        key_in = rand_key();
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore");
        cmp_logs("ignore");
        @(posedge clk);
        #1;

        // Asynchronous reset mid-schedule
        do_start(GOLD_KEY, 1'b0);
        wait_round(4'd9);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(subkey_valid), 64'd0);
        chk("midrst_round", 64'(round), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_subkey", 64'(subkey), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start(GOLD_KEY, 1'b0);
        chk("restart_K16", 64'(subkey), 64'(GOLD_K16));
        chk("restart_round", 64'(round), 64'd0);
        wait_done("restart");

        // Start on the cycle done is high
        do_start(rand_key(), 1'b0);
        chk("coinc_valid", 64'(subkey_valid), 64'd1);
        chk("coinc_busy", 64'(busy), 64'd1);
        wait_done("coinc");
        @(posedge clk);
        #1;

        // Random keys with random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            k = rand_key();
`ifdef KEYSCHED_ENC_EN
            enc = ($urandom_range(0, 1) == 1);
`else
            enc = 1'b0;
`endif
            do_start(k, enc);
            wait_done($sformatf("rand%0d", n));
            @(posedge clk);
            #1;
        end
        rand_ready = 1'b0;

`ifdef KEYSCHED_ENC_EN
        acc_log.delete();
        do_start(GOLD_KEY, 1'b1);
        wait_done("enc");
        chk("enc_len", 64'(acc_log.size()), 64'd16);
        if (acc_log.size() == 16) begin
            chk("enc_K1", 64'(acc_log[0]), 64'(GOLD_K1));
            chk("enc_K2", 64'(acc_log[1]), 64'(GOLD_K2));
            chk("enc_K16", 64'(acc_log[15]), 64'(GOLD_K16));
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
